// File: rtl/display_scan_mux.sv
// display_scan_mux
//   Time-multiplexing scan controller for a 4-digit seven-segment decoder.
//   A prescaler divides clk down to one digit slot every REFRESH_DIV cycles.
//   A 2-bit digit index steps once per slot. The active 4-nibble word is mapped
//   to a decoder code for the current digit. A new word is taken over
//   valid/ready into a one-entry pending buffer. It becomes active only at a
//   frame boundary (digit 3 -> 0), so a partially updated word is never shown.
// Ports
//   clk         rising-edge system clock
//   rst_n       asynchronous active-low reset
//   load_valid  new display word offered
//   load_ready  pending buffer free; accept on load_valid & load_ready
//   digits_in   [15:12] digit 0 (leftmost) .. [3:0] digit 3 (rightmost)
//   blank_in    bit i blanks digit i; captured with digits_in
//   en          registered digit index (0 = leftmost)
//   bcd         registered decoder code: 0-9 digit, 10 dash, 12 blank
//   frame_tick  one-cycle pulse following each digit 3 -> 0 step
module display_scan_mux #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned CNT_W       = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [15:0] digits_in,
  input  logic [3:0]  blank_in,
  output logic [1:0]  en,
  output logic [3:0]  bcd,
  output logic        frame_tick
);

  localparam logic [15:0] ResetWord  = 16'hCCCC;
  localparam logic [3:0]  ResetBlank = 4'hF;
  localparam logic [3:0]  CodeBlank  = 4'd12;

  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_idx;
  logic [15:0]      r_act_digits;
  logic [3:0]       r_act_blank;
  logic [15:0]      r_pend_digits;
  logic [3:0]       r_pend_blank;
  logic             r_pend_full;
  logic             r_ready;
  logic [3:0]       r_bcd;
  logic             r_frame_tick;

  logic        w_slot_end;
  logic        w_frame_end;
  logic        w_commit;
  logic        w_accept;
  logic [1:0]  w_idx_next;
  logic [15:0] w_digits_next;
  logic [3:0]  w_blank_next;
  logic [3:0]  w_nib_next;
  logic [3:0]  w_bcd_next;

  // Blank bit and illegal nibbles (11-15) both show as blank.
  function automatic logic [3:0] f_map(input logic [3:0] nib, input logic blank);
    logic [3:0] code;
    code = nib;
    if (blank || (nib > 4'd10)) code = CodeBlank;
    return code;
  endfunction

  assign w_slot_end  = (r_cnt == CNT_W'(REFRESH_DIV - 1));
  assign w_frame_end = w_slot_end && (r_idx == 2'd3);
  assign w_commit    = w_frame_end && r_pend_full;
  assign w_accept    = load_valid && r_ready;
  assign w_idx_next  = r_idx + 2'd1;

  // The code for the next slot comes from the word that is active after this
  // edge, so a commit shows the new word's digit 0 immediately.
  assign w_digits_next = w_commit ? r_pend_digits : r_act_digits;
  assign w_blank_next  = w_commit ? r_pend_blank  : r_act_blank;

  always_comb begin
    w_nib_next = w_digits_next[15:12];
    unique case (w_idx_next)
      2'd0: w_nib_next = w_digits_next[15:12];
      2'd1: w_nib_next = w_digits_next[11:8];
      2'd2: w_nib_next = w_digits_next[7:4];
      2'd3: w_nib_next = w_digits_next[3:0];
      default: w_nib_next = w_digits_next[15:12];
    endcase
  end

  assign w_bcd_next = f_map(w_nib_next, w_blank_next[w_idx_next]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt         <= '0;
      r_idx         <= 2'd0;
      r_act_digits  <= ResetWord;
      r_act_blank   <= ResetBlank;
      r_pend_digits <= '0;
      r_pend_blank  <= '0;
      r_pend_full   <= 1'b0;
      r_ready       <= 1'b1;
      r_bcd         <= CodeBlank;
      r_frame_tick  <= 1'b0;
    end else begin
      r_cnt        <= w_slot_end ? '0 : r_cnt + CNT_W'(1);
      r_frame_tick <= w_frame_end;
      if (w_slot_end) begin
        r_idx <= w_idx_next;
        r_bcd <= w_bcd_next;
      end
      if (w_commit) begin
        r_act_digits <= r_pend_digits;
        r_act_blank  <= r_pend_blank;
      end
      if (w_commit) begin
        r_pend_full <= 1'b0;
      end else if (w_accept) begin
        r_pend_full <= 1'b1;
      end
      if (w_accept) begin
        r_pend_digits <= digits_in;
        r_pend_blank  <= blank_in;
      end
      // Ready returns one cycle after the commit empties the pending buffer.
      r_ready <= w_accept ? 1'b0 : ~r_pend_full;
    end
  end

  assign load_ready = r_ready;
  assign en         = r_idx;
  assign bcd        = r_bcd;
  assign frame_tick = r_frame_tick;

endmodule
